// File: rtl/sn74123.sv
// sn74123: one retriggerable monostable section, fully synchronous to i_mclk.
// The external RC timing is replaced by a pulse width counted in i_mclk cycles.
// Every input is sampled on i_mclk. Edges are found by comparing each input
// with its value from the previous cycle.
//
// Parameters:
//   WIDTH  - pulse width in i_mclk cycles (legal range 1 .. 2**CW-1)
//   CW     - width of the down-counter
//   RETRIG - 1: a trigger during a pulse restarts the timing; 0: it is ignored
// Ports:
//   i_mclk  - master clock, rising edge
//   i_rst   - synchronous active-high reset
//   i_a_n   - active-low trigger; a falling edge triggers
//   i_b     - active-high trigger; a rising edge triggers
//   i_clr_n - active-low clear; its rising edge also triggers
//   o_q     - registered pulse output
//   o_q_n   - registered complement of o_q
module sn74123 #(
   parameter int unsigned WIDTH  = 100,
   parameter int unsigned CW     = 16,
   parameter bit          RETRIG = 1'b1
) (
   input  logic i_mclk,
   input  logic i_rst,
   input  logic i_a_n,
   input  logic i_b,
   input  logic i_clr_n,
   output logic o_q,
   output logic o_q_n
);

   localparam logic [CW-1:0] LP_RELOAD = CW'(WIDTH - 1);
   localparam logic [CW-1:0] LP_ONE    = CW'(1);

   typedef enum logic {StIdle, StActive} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_q;
   logic          r_q_n;
   logic          r_old_a_n;
   logic          r_old_b;
   logic          r_old_clr_n;

   logic w_edge;
   logic w_trig;
   logic w_accept;

   // Several simultaneous edges OR together into a single trigger.
   assign w_edge   = r_old_a_n | ~r_old_b | ~r_old_clr_n;
   assign w_trig   = ~i_a_n & i_b & i_clr_n & w_edge;
   assign w_accept = w_trig & (RETRIG | (r_state == StIdle));

   // The history registers load even during reset. An input level held
   // across reset therefore never looks like an edge when reset is released.
   always_ff @(posedge i_mclk) begin
      r_old_a_n   <= i_a_n;
      r_old_b     <= i_b;
      r_old_clr_n <= i_clr_n;
   end

   always_ff @(posedge i_mclk) begin
      if (i_rst || !i_clr_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_q     <= 1'b0;
         r_q_n   <= 1'b1;
      end else if (w_accept) begin
         r_state <= StActive;
         r_cnt   <= LP_RELOAD;
         r_q     <= 1'b1;
         r_q_n   <= 1'b0;
      end else begin
         unique case (r_state)
            StActive: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - LP_ONE;
               end else begin
                  r_state <= StIdle;
                  r_q     <= 1'b0;
                  r_q_n   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_q   = r_q;
   assign o_q_n = r_q_n;

endmodule

// File: tb/tb_sn74123.sv
// Self-checking bench for sn74123. Four instances with different WIDTH/RETRIG
// values share the same stimulus. The reference model records, for each
// instance, the cycle at which the current pulse ends and derives q from that.
module tb_sn74123;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_n = 1'b1;
   logic       b = 1'b1;
   logic       clr_n = 1'b1;
   logic [3:0] q;
   logic [3:0] q_n;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sn74123 #(.WIDTH(100), .CW(16), .RETRIG(1'b1)) u_w100 (
      .i_mclk(clk), .i_rst(rst), .i_a_n(a_n), .i_b(b), .i_clr_n(clr_n),
      .o_q(q[0]), .o_q_n(q_n[0]));
   sn74123 #(.WIDTH(10), .CW(16), .RETRIG(1'b1)) u_w10r (
      .i_mclk(clk), .i_rst(rst), .i_a_n(a_n), .i_b(b), .i_clr_n(clr_n),
      .o_q(q[1]), .o_q_n(q_n[1]));
   sn74123 #(.WIDTH(10), .CW(16), .RETRIG(1'b0)) u_w10n (
      .i_mclk(clk), .i_rst(rst), .i_a_n(a_n), .i_b(b), .i_clr_n(clr_n),
      .o_q(q[2]), .o_q_n(q_n[2]));
   sn74123 #(.WIDTH(1), .CW(4), .RETRIG(1'b1)) u_w1 (
      .i_mclk(clk), .i_rst(rst), .i_a_n(a_n), .i_b(b), .i_clr_n(clr_n),
      .o_q(q[3]), .o_q_n(q_n[3]));

   // Reference model. At edge n the output is high iff n < end_t[k].
   int         m_w [4] = '{100, 10, 10, 1};
   bit         m_rt[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   int         end_t[4] = '{0, 0, 0, 0};
   int         cyc = 0;
   logic       pa = 1'b1;
   logic       pb = 1'b1;
   logic       pc = 1'b1;
   logic [3:0] sb[$];

   always @(posedge clk) begin
      logic       trig;
      logic       high_now;
      logic [3:0] exp_q;
      trig = !a_n && b && clr_n && (pa || !pb || !pc);
      for (int k = 0; k < 4; k++) begin
         high_now = (cyc - 1 < end_t[k]);
         if (rst || !clr_n) end_t[k] = cyc;
         else if (trig && (m_rt[k] || !high_now)) end_t[k] = cyc + m_w[k];
         exp_q[k] = (cyc < end_t[k]);
      end
      sb.push_back(exp_q);
      pa = a_n;
      pb = b;
      pc = clr_n;
      cyc++;
   end

   // Monitor: compares both outputs of every instance each cycle.
   initial begin
      logic [3:0] e;
      forever begin
         @(posedge clk);
         #1;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty at time %0t: got no entry, required one", $time);
         end else begin
            e = sb.pop_front();
            for (int k = 0; k < 4; k++) begin
               tests += 2;
               if (q[k] !== e[k]) begin
                  fails++;
                  $display("FAIL q dut%0d edge %0d: got %b, required %b", k, cyc - 1, q[k], e[k]);
               end
               if (q_n[k] !== !e[k]) begin
                  fails++;
                  $display("FAIL q_n dut%0d edge %0d: got %b, required %b", k, cyc - 1, q_n[k],
                           !e[k]);
               end
            end
         end
      end
   end

   task automatic drive(input logic r, input logic a, input logic bb, input logic c,
                        input int n);
      rst   = r;
      a_n   = a;
      b     = bb;
      clr_n = c;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // Reset held 2 cycles, idle to cycle 4, a_n falls at cycle 5.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 2);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 3);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 110);
      // Retrigger: b rises, drops at +5, rises again at +6.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 5);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 5);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 110);
      // Clear at +3, clear-trigger at +6.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 3);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 3);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 110);
      // Simultaneous a_n fall and b rise, then held.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 110);
      // Reset in the middle of a pulse, inputs unchanged afterwards.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 2);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 2);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 110);
      // Random stimulus.
      for (int i = 0; i < 3000; i++) begin
         logic r, a, bb, c;
         a  = ($urandom_range(0, 5) == 0) ? !a_n : a_n;
         bb = ($urandom_range(0, 5) == 0) ? !b : b;
         if (clr_n) c = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
         else c = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
         r = ($urandom_range(0, 199) == 0);
         drive(r, a, bb, c, 1);
      end
      drive(1'b0, a_n, b, 1'b1, 3);
      tests++;
      if (sb.size() > 1) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d entries left, required at most 1", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sn74123.md
# sn74123

Retriggerable monostable multivibrator (one-shot) model of one SN74123 section, synchronous to the master clock `mclk`. It generates the timed pulses that drive edge-triggered flip-flop clock, preset and clear inputs elsewhere in the PDP-8/I logic. The real part's external RC timing is replaced by a pulse width counted in `mclk` cycles. All inputs are sampled, and all edges are detected by comparing against the previous `mclk` sample; there are no asynchronous paths.

## Interface
- `WIDTH`, default 100: output pulse width in `mclk` cycles. Legal range is 1..2^CW-1; values outside it are illegal.
- `CW`, default 16: width of the internal down-counter.
- `RETRIG`, default 1:
  - 1: a trigger during an active pulse restarts the timing (74123 behaviour).
  - 0: triggers during an active pulse are ignored (74121-style).
- `mclk` input, 1 bit: master clock. Every register updates on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `a_n` input, 1 bit: active-low trigger input. A falling edge triggers.
- `b` input, 1 bit: active-high trigger input. A rising edge triggers.
- `clr_n` input, 1 bit: active-low clear. Its rising edge also triggers.
- `q` output, 1 bit, registered: pulse output.
- `q_n` output, 1 bit, registered: complementary pulse output.

## Operation
- Registers:
  - Input history: `old_a_n`, `old_b`, `old_clr_n`. These load `a_n`, `b` and `clr_n` every cycle, including cycles with `rst` high.
  - `cnt[CW-1:0]`.
  - `q` and `q_n`.
- Reset (`rst`=1): `q`=0, `q_n`=1, `cnt`=0.
  - The history registers load the current inputs, so an input level held across reset never produces a trigger when reset is released.
- Trigger condition `trig` is evaluated on the current inputs and the history registers. It is true when `a_n`=0, `b`=1, `clr_n`=1, and at least one of the following holds:
  - `a_n` fell (`old_a_n`=1);
  - `b` rose (`old_b`=0);
  - `clr_n` rose (`old_clr_n`=0).
- Two or three of these edges in the same cycle produce one trigger, not several.
- Priority per `mclk` edge, highest first:
  1. `rst`.
  2. `clr_n`=0: `q`=0, `q_n`=1, `cnt`=0. Any active pulse ends immediately. `trig` is false while `clr_n` is low.
  3. `trig`, and either `RETRIG`=1 or `q`=0: `q`=1, `q_n`=0, `cnt`=WIDTH-1.
  4. `q`=1 and `cnt`≠0: `cnt` decrements by 1.
  5. `q`=1 and `cnt`=0: `q`=0, `q_n`=1. The pulse ends.
  6. Otherwise all registers hold.
- States:
  - IDLE: `q`=0.
  - ACTIVE: `q`=1.
  - IDLE goes to ACTIVE on `trig`.
  - ACTIVE goes to IDLE on count expiry or `clr_n`=0.
  - ACTIVE stays ACTIVE with the count reloaded on `trig`, only when `RETRIG`=1.
- `q_n` is always `!q`. Outside simulation-time X states there is no both-high case, unlike a flip-flop with preset and clear both asserted.
- Arithmetic: the counter only decrements and never wraps, because it stops at 0.

## Timing
- Trigger latency: `q` rises on the first `mclk` edge at which the new input level is sampled. This is the same edge-sampling rule the flip-flop models use.
- Pulse width: `q` is high for exactly `WIDTH` `mclk` cycles after an unretriggered trigger.
  - `WIDTH`=1 gives a single-cycle pulse.
- Retrigger (`RETRIG`=1): a trigger at cycle t while `q`=1 keeps `q` high through cycle t+WIDTH-1. `q` falls at edge t+WIDTH.
- Non-retriggerable (`RETRIG`=0): a trigger while `q`=1 is discarded. It is not queued.
  - A trigger on the same edge that `q` falls is also discarded, because `q`=1 on that edge.
- Clear: `clr_n`=0 forces `q` low on that same edge, including when a trigger edge occurs in the same cycle.
  - The `clr_n` rising edge with `a_n`=0 and `b`=1 starts a new pulse on the edge it is sampled.
- Reset mid-pulse: `q` goes to 0 on that edge. No pulse resumes after reset is released.
- Held inputs (`a_n`=0, `b`=1 steady) never retrigger. Only edges trigger.

## Test plan
- Reset, then check outputs at rest: hold `rst`=1 for 2 cycles with `b`=1 and `a_n`=1, then release and drop `a_n` at cycle 5.
  - Required: `q`=0 and `q_n`=1 through cycle 4.
  - Required: `q`=1 from edge 5 for exactly 100 cycles, then `q`=0.
- Retrigger with `WIDTH`=10 and `RETRIG`=1: `b` rises at cycle 0; toggle `b` low at cycle 5 and high again at cycle 6.
  - Required: `q` high from edge 0 through cycle 15, falling at edge 16.
- Non-retriggerable, same stimulus with `RETRIG`=0.
  - Required: `q` falls at edge 10; the cycle-6 trigger is ignored.
- Clear and clear-trigger with `WIDTH`=10: trigger at cycle 0, `clr_n`=0 at cycle 3, `clr_n`=1 at cycle 6 with `a_n`=0 and `b`=1.
  - Required: `q` falls at edge 3, rises at edge 6, and falls at edge 16.
- Simultaneous edges and minimum width with `WIDTH`=1: `a_n` falls and `b` rises on the same cycle.
  - Required: exactly one single-cycle `q` pulse.
  - Required: no further pulse while the inputs are held.
- Reset mid-pulse: assert `rst` at cycle 4 of a 10-cycle pulse.
  - Required: `q`=0 from edge 4.
  - Required: no pulse after release while the inputs are unchanged.
